// File: rtl/spi_link.sv
// SPI mode-0 master and slave joined on one internal 4-wire bus; one full-duplex
// byte per start request, with the bus wires exposed for observation.

module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       start_transfer,
  input  logic       miso,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  output logic       transfer_done,
  output logic [7:0] rx_data
);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, DONE} state_t;

  state_t        current_state;
  logic [CW-1:0] div_cnt;
  logic [4:0]    half_cnt;
  logic [7:0]    master_tx_data;
  logic [7:0]    master_rx_data;
  logic          div_end;

  assign div_end = (div_cnt == CW'(CLK_DIV - 1));

  // half_cnt 0..15 are the SCLK half-periods; 16 is the trailing hold with SCLK low
  always_ff @(posedge clk) begin
    if (rst_n) begin
      current_state  <= IDLE;
      div_cnt        <= '0;
      half_cnt       <= '0;
      master_tx_data <= '0;
      master_rx_data <= '0;
      sclk           <= 1'b0;
      ss_n           <= 1'b1;
      mosi           <= 1'b0;
      transfer_done  <= 1'b0;
      rx_data        <= '0;
    end else begin
      transfer_done <= 1'b0;
      case (current_state)
        IDLE: begin
          ss_n <= 1'b1;
          sclk <= 1'b0;
          if (start_transfer) begin
            master_tx_data <= tx_data;
            mosi           <= tx_data[7];
            ss_n           <= 1'b0;
            div_cnt        <= '0;
            current_state  <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_cnt       <= '0;
            half_cnt      <= '0;
            current_state <= TRANSFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TRANSFER: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 1'b1;
            if (half_cnt == 5'd16) begin
              ss_n          <= 1'b1;
              transfer_done <= 1'b1;
              rx_data       <= master_rx_data;
              current_state <= DONE;
            end else if (!half_cnt[0]) begin
              sclk           <= 1'b1;
              master_rx_data <= {master_rx_data[6:0], miso};
            end else begin
              sclk <= 1'b0;
              if (half_cnt != 5'd15) begin
                master_tx_data <= {master_tx_data[6:0], 1'b0};
                mosi           <= master_tx_data[6];
              end
            end
          end
        end
        DONE: current_state <= IDLE;
        default: current_state <= IDLE;
      endcase
    end
  end
endmodule

module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic [7:0] slave_tx_data,
  output logic       miso,
  output logic       data_received,
  output logic [7:0] slave_rx_data
);
  typedef struct packed {
    logic sclk;
    logic ss_n;
    logic mosi;
  } bus_t;

  typedef enum logic {S_IDLE, S_ACTIVE} slave_state_t;

  localparam bus_t BUS_IDLE = '{sclk: 1'b0, ss_n: 1'b1, mosi: 1'b0};

  slave_state_t current_slave_state;
  bus_t         sync1, sync2;
  logic         sclk_q, ss_q;
  logic [7:0]   tx_shift, rx_shift;
  logic [2:0]   bit_cnt;
  logic         sclk_rise, sclk_fall, ss_fall, ss_rise;

  assign sclk_rise = sync2.sclk & ~sclk_q;
  assign sclk_fall = ~sync2.sclk & sclk_q;
  assign ss_fall   = ~sync2.ss_n & ss_q;
  assign ss_rise   = sync2.ss_n & ~ss_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1  <= BUS_IDLE;
      sync2  <= BUS_IDLE;
      sclk_q <= 1'b0;
      ss_q   <= 1'b1;
    end else begin
      sync1  <= '{sclk: sclk, ss_n: ss_n, mosi: mosi};
      sync2  <= sync1;
      sclk_q <= sync2.sclk;
      ss_q   <= sync2.ss_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      current_slave_state <= S_IDLE;
      tx_shift            <= '0;
      rx_shift            <= '0;
      bit_cnt             <= '0;
      miso                <= 1'b0;
      data_received       <= 1'b0;
      slave_rx_data       <= '0;
    end else begin
      data_received <= 1'b0;
      case (current_slave_state)
        S_IDLE: begin
          miso <= 1'b0;
          if (ss_fall) begin
            tx_shift            <= slave_tx_data;
            miso                <= slave_tx_data[7];
            bit_cnt             <= '0;
            current_slave_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // deselect drops any partial byte without a pulse
          if (ss_rise || sync2.ss_n) begin
            miso                <= 1'b0;
            current_slave_state <= S_IDLE;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[6:0], sync2.mosi};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              data_received <= 1'b1;
              slave_rx_data <= {rx_shift[6:0], sync2.mosi};
            end
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            miso     <= tx_shift[6];
          end
        end
        default: current_slave_state <= S_IDLE;
      endcase
    end
  end
endmodule

module spi_link #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       start_transfer,
  output logic       transfer_done,
  output logic [7:0] rx_data,
  input  logic [7:0] slave_tx_data,
  output logic [7:0] slave_rx_data,
  output logic       data_received,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  output logic       miso
);
  spi_master #(.CLK_DIV(CLK_DIV)) u_master (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .start_transfer (start_transfer),
    .miso           (miso),
    .sclk           (sclk),
    .ss_n           (ss_n),
    .mosi           (mosi),
    .transfer_done  (transfer_done),
    .rx_data        (rx_data)
  );

  spi_slave u_slave (
    .clk           (clk),
    .rst_n         (rst_n),
    .sclk          (sclk),
    .ss_n          (ss_n),
    .mosi          (mosi),
    .slave_tx_data (slave_tx_data),
    .miso          (miso),
    .data_received (data_received),
    .slave_rx_data (slave_rx_data)
  );
endmodule

// File: tb/tb_spi_link.sv
// Randomized bench for spi_link: each transfer is checked against the byte swap
// it should perform, the MSB-first MOSI stream and the start-to-done latency.

module tb_spi_link;
  localparam int CLK_DIV = 4;
  localparam int LAT     = 18 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = '0;
  logic       start_transfer = 1'b0;
  logic       transfer_done;
  logic [7:0] rx_data;
  logic [7:0] slave_tx_data = '0;
  logic [7:0] slave_rx_data;
  logic       data_received;
  logic       sclk, ss_n, mosi, miso;

  int total = 0;
  int bad   = 0;

  // observations of the most recent do_xfer
  int         o_lat, o_width, o_recv, o_rises;
  logic       o_recv_first, o_ss0, o_timeout;
  logic [7:0] o_mosi, o_rx, o_srx;

  spi_link #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .start_transfer (start_transfer),
    .transfer_done  (transfer_done),
    .rx_data        (rx_data),
    .slave_tx_data  (slave_tx_data),
    .slave_rx_data  (slave_rx_data),
    .data_received  (data_received),
    .sclk           (sclk),
    .ss_n           (ss_n),
    .mosi           (mosi),
    .miso           (miso)
  );

  always #5 clk = ~clk;

  // one-cycle start, then watch the bus until one cycle past transfer_done;
  // glitch_k >= 0 pulses start with different bytes k cycles into the transfer
  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] stx, input int glitch_k);
    logic prev_sclk;
    bit   seen;
    prev_sclk = 1'b0; seen = 0;
    o_lat = -1; o_width = 0; o_recv = 0; o_rises = 0;
    o_recv_first = 1'b0; o_ss0 = 1'b1; o_mosi = '0; o_rx = '0; o_srx = '0;
    @(negedge clk);
    tx_data = tx; slave_tx_data = stx; start_transfer = 1'b1;
    @(posedge clk);
    #1 start_transfer = 1'b0;
    for (int k = 0; k < LAT + 40; k++) begin
      @(negedge clk);
      if (k == 0) o_ss0 = ss_n;
      if (sclk && !prev_sclk) begin
        if (o_rises < 8) o_mosi[7 - o_rises] = mosi;
        o_rises++;
      end
      prev_sclk = sclk;
      if (data_received) o_recv++;
      if (k == glitch_k) begin
        start_transfer = 1'b1; tx_data = ~tx; slave_tx_data = ~stx;
      end else if (k == glitch_k + 1) begin
        start_transfer = 1'b0;
      end
      if (seen) begin
        o_width = transfer_done ? 2 : 1;
        break;
      end
      if (transfer_done) begin
        seen = 1; o_lat = k; o_rx = rx_data; o_srx = slave_rx_data;
        o_recv_first = (o_recv == 1);
      end
    end
    o_timeout = !seen;
  endtask

  task automatic test_reset();
    logic idle_ok;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++; if ({sclk, ss_n, mosi, miso, transfer_done, data_received} !== 6'b010000) begin
      bad++; $display("FAIL reset_bits: got %b want 010000", {sclk, ss_n, mosi, miso, transfer_done, data_received});
    end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    total++; if (slave_rx_data !== 8'h00) begin bad++; $display("FAIL reset_srx: got %h want 00", slave_rx_data); end
    idle_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ss_n !== 1'b1 || sclk !== 1'b0) idle_ok = 1'b0;
    end
    total++; if (idle_ok !== 1'b1) begin bad++; $display("FAIL reset_idle_bus: got %b want 1", idle_ok); end
  endtask

  task automatic test_basic();
    do_xfer(8'h5A, 8'hAA, -1);
    total++; if (o_timeout) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    total++; if (o_ss0 !== 1'b0) begin bad++; $display("FAIL basic_ss_low: got %b want 0", o_ss0); end
    total++; if (o_lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", o_lat, LAT); end
    total++; if (o_width != 1) begin bad++; $display("FAIL basic_done_width: got %0d want 1", o_width); end
    total++; if (o_rises != 8) begin bad++; $display("FAIL basic_sclk_rises: got %0d want 8", o_rises); end
    total++; if (o_mosi !== 8'h5A) begin bad++; $display("FAIL basic_mosi: got %h want 5a", o_mosi); end
    total++; if (o_recv != 1) begin bad++; $display("FAIL basic_recv_count: got %0d want 1", o_recv); end
    total++; if (o_recv_first !== 1'b1) begin bad++; $display("FAIL basic_recv_order: got %b want 1", o_recv_first); end
    total++; if (o_rx !== 8'hAA) begin bad++; $display("FAIL basic_rx: got %h want aa", o_rx); end
    total++; if (o_srx !== 8'h5A) begin bad++; $display("FAIL basic_srx: got %h want 5a", o_srx); end
    repeat (5) @(negedge clk);
    total++; if (rx_data !== 8'hAA) begin bad++; $display("FAIL basic_rx_hold: got %h want aa", rx_data); end
  endtask

  task automatic test_patterns();
    logic [7:0] txq[$];
    logic [7:0] stxq[$];
    txq = '{8'hC3, 8'h12};
    stxq = '{8'hB5, 8'h00};
    for (int i = 0; i < 6; i++) begin
      txq.push_back(8'($urandom));
      stxq.push_back(8'($urandom));
    end
    foreach (txq[i]) begin
      do_xfer(txq[i], stxq[i], -1);
      // the exchange is a plain swap: master gets the slave byte and vice versa
      total++; if (o_lat != LAT) begin bad++; $display("FAIL pat%0d_latency: got %0d want %0d", i, o_lat, LAT); end
      total++; if (o_rx !== stxq[i]) begin bad++; $display("FAIL pat%0d_rx: got %h want %h", i, o_rx, stxq[i]); end
      total++; if (o_srx !== txq[i]) begin bad++; $display("FAIL pat%0d_srx: got %h want %h", i, o_srx, txq[i]); end
      total++; if (o_mosi !== txq[i]) begin bad++; $display("FAIL pat%0d_mosi: got %h want %h", i, o_mosi, txq[i]); end
      total++; if (o_recv != 1) begin bad++; $display("FAIL pat%0d_recv: got %0d want 1", i, o_recv); end
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] tx, stx;
    logic       quiet;
    tx = 8'($urandom); stx = 8'($urandom);
    do_xfer(tx, stx, 30);
    total++; if (o_lat != LAT) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", o_lat, LAT); end
    total++; if (o_rx !== stx) begin bad++; $display("FAIL ignore_rx: got %h want %h", o_rx, stx); end
    total++; if (o_srx !== tx) begin bad++; $display("FAIL ignore_srx: got %h want %h", o_srx, tx); end
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ss_n !== 1'b1) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL ignore_no_retrigger: got %b want 1", quiet); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tx1, stx1, tx2, stx2;
    int         done2;
    tx1 = 8'($urandom); stx1 = 8'($urandom); tx2 = 8'($urandom); stx2 = 8'($urandom);
    done2 = -1;
    @(negedge clk);
    tx_data = tx1; slave_tx_data = stx1; start_transfer = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2 * LAT + 20; k++) begin
      @(negedge clk);
      if (k == LAT) begin
        total++; if (transfer_done !== 1'b1 || rx_data !== stx1) begin
          bad++; $display("FAIL b2b_first: got done=%b rx=%h want done=1 rx=%h", transfer_done, rx_data, stx1);
        end
      end
      if (k == LAT + 1) begin
        total++; if (ss_n !== 1'b1) begin bad++; $display("FAIL b2b_gap: got ss_n=%b want 1", ss_n); end
        tx_data = tx2; slave_tx_data = stx2;
      end
      if (k == LAT + 2) begin
        total++; if (ss_n !== 1'b0) begin bad++; $display("FAIL b2b_restart: got ss_n=%b want 0", ss_n); end
        start_transfer = 1'b0;
      end
      if (k > LAT + 2 && transfer_done) begin
        done2 = k;
        total++; if (rx_data !== stx2 || slave_rx_data !== tx2) begin
          bad++; $display("FAIL b2b_second: got rx=%h srx=%h want rx=%h srx=%h", rx_data, slave_rx_data, stx2, tx2);
        end
        break;
      end
    end
    start_transfer = 1'b0;
    total++; if (done2 != 2 * LAT + 2) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", done2, 2 * LAT + 2); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] tx, stx;
    logic       prev_sclk, quiet;
    int         rises;
    tx = 8'($urandom); stx = 8'($urandom);
    prev_sclk = 1'b0; rises = 0;
    @(negedge clk);
    tx_data = tx; slave_tx_data = stx; start_transfer = 1'b1;
    @(posedge clk);
    #1 start_transfer = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rises == 4) break;
    end
    total++; if (rises != 4) begin bad++; $display("FAIL rmid_reach4: got %0d want 4", rises); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ss_n !== 1'b1 || sclk !== 1'b0) begin bad++; $display("FAIL rmid_bus: got ss_n=%b sclk=%b want 1 0", ss_n, sclk); end
    total++; if (rx_data !== 8'h00 || slave_rx_data !== 8'h00) begin
      bad++; $display("FAIL rmid_rx_clear: got rx=%h srx=%h want 00 00", rx_data, slave_rx_data);
    end
    #1 rst_n = 1'b0;
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (transfer_done !== 1'b0 || data_received !== 1'b0 || ss_n !== 1'b1) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL rmid_no_pulse: got %b want 1", quiet); end
    tx = 8'($urandom); stx = 8'($urandom);
    do_xfer(tx, stx, -1);
    total++; if (o_lat != LAT) begin bad++; $display("FAIL rmid_after_latency: got %0d want %0d", o_lat, LAT); end
    total++; if (o_rx !== stx || o_srx !== tx) begin
      bad++; $display("FAIL rmid_after_data: got rx=%h srx=%h want rx=%h srx=%h", o_rx, o_srx, stx, tx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_link.md
# spi_link

Single-clock SPI link block: an `spi_master` and an `spi_slave` instantiated together and wired through a shared 4-wire bus (SCLK, SS_N, MOSI, MISO). It runs one full-duplex 8-bit exchange per start request: the master shifts `tx_data` out while capturing the slave's `slave_tx_data`, and the slave captures the master's byte. It sits as a self-contained serial transport and loopback unit between host-side register logic and the SPI pins. The bus wires are brought out for observation.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; integer ≥ 4.
- clk  in  1  system clock; both sub-blocks use it.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1) despite the name.
- tx_data  in  8  master transmit byte; latched when a start is accepted.
- start_transfer  in  1  start request; sampled high in IDLE only.
- transfer_done  out  1  one-cycle pulse; rx_data valid.
- rx_data  out  8  byte received by the master.
- slave_tx_data  in  8  slave transmit byte; latched when the slave sees SS_N fall.
- slave_rx_data  out  8  byte received by the slave.
- data_received  out  1  one-cycle slave pulse; slave_rx_data valid.
- sclk, ss_n, mosi, miso  out  1 each  internal SPI bus, for observation.

## Operation
- SPI mode 0: CPOL=0, CPHA=0. MSB first. 8 bits per transfer.
- Master FSM states (`current_state`): IDLE, SETUP, TRANSFER, DONE.
  - IDLE: ss_n=1, sclk=0. `start_transfer`=1 latches `tx_data` into shift register `master_tx_data`, then goes to SETUP.
  - SETUP: ss_n=0, mosi=bit7. Lasts CLK_DIV cycles, then goes to TRANSFER.
  - TRANSFER: 16 half-periods of CLK_DIV cycles each. sclk rises at the end of odd half-periods and falls at the end of even ones.
  - On each rise, miso shifts into `master_rx_data` (LSB in).
  - On each fall except the last, the next tx bit goes onto mosi.
  - After the 16th half-period (sclk low): one hold half-period of CLK_DIV cycles with ss_n still 0, then DONE.
  - DONE (1 cycle): ss_n=1, transfer_done=1, rx_data←master_rx_data, then IDLE.
- `start_transfer` outside IDLE is ignored; a held start re-triggers only after returning to IDLE.
- Slave FSM states (`current_slave_state`): IDLE, ACTIVE.
  - The slave samples sclk, ss_n and mosi through 2-flop synchronizers and detects edges on the synchronized signals.
  - SS_N falling edge: latch `slave_tx_data`, drive its bit7 on miso, clear the bit counter, go to ACTIVE.
  - ACTIVE, sclk rise: shift mosi into `slave_rx_data` shift register.
  - ACTIVE, sclk fall: present the next tx bit on miso.
  - ACTIVE, 8th rise: next cycle pulse data_received=1 and update slave_rx_data.
  - SS_N rising edge, or SS_N high in ACTIVE: go to IDLE; an incomplete byte is discarded with no pulse.
  - miso = 0 whenever the slave is IDLE.
- rx_data and slave_rx_data hold their values until the next completed transfer.

## Timing
- Reset values: sclk=0, ss_n=1, mosi=0, miso=0, transfer_done=0, data_received=0, rx_data=0x00, slave_rx_data=0x00, both FSMs IDLE, all shift registers and counters 0.
- Reset applies on any clk edge where rst_n=1, including mid-transfer: ss_n returns to 1 and no done or received pulse occurs.
- Start sampled on edge E0 → ss_n low after E0.
- transfer_done is high in the cycle after edge E0+18·CLK_DIV. At CLK_DIV=4 that is 73 cycles from start to done.
- Earliest next start is accepted the cycle after DONE.
- Slave synchronizer latency is 2–3 clk. CLK_DIV ≥ 4 guarantees miso settles before the master's sampling rise.
- data_received pulses 3–4 cycles after the 8th sclk rise. It always precedes transfer_done.

## Test plan
- Reset held 2 cycles, then released → every output equals its reset value; ss_n=1 and sclk=0 throughout idle.
- tx_data=0x5A, slave_tx_data=0xAA, 1-cycle start → mosi bits 0,1,0,1,1,0,1,0; slave_rx_data=0x5A with one data_received pulse; rx_data=0xAA at a one-cycle transfer_done, 73 cycles after start.
- tx_data=0xC3, slave_tx_data=0xB5 → rx_data=0xB5, slave_rx_data=0xC3.
- tx_data=0x12, slave_tx_data=0x00 → rx_data=0x00, slave_rx_data=0x12.
- Pulse start again mid-transfer, with a different tx_data → ignored; the current byte completes unchanged.
- Assert rst_n mid-transfer after the 4th sclk rise → ss_n=1 next cycle, no pulses, both rx registers 0x00; the next transfer works normally.
